// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter in front of the data bus decoder's single port.
// Tracks in-flight transactions in an ordered ID FIFO and routes in-order responses back.
module data_bus_arbiter #(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [3:0]        s_be_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_wdata_o,
  input  logic              s_gnt_i,
  input  logic              s_rvalid_i,
  input  logic [31:0]       s_rdata_i,

  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [MAX_OUT-1:0] r_ids;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_last_grant;
  logic               r_err;

  logic w_issue_ok;
  logic w_any_req;
  logic w_sel_id;
  logic w_grant;
  logic w_pop;
  logic w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin selection: on contention the master not granted last wins.
  always_comb begin
    w_issue_ok = (r_count < CNT_W'(MAX_OUT));
    w_any_req  = m0_req_i | m1_req_i;
    w_sel_id   = (m0_req_i & m1_req_i) ? ~r_last_grant : m1_req_i;
    w_head     = r_ids[r_rd_ptr];
    w_grant    = s_req_o & s_gnt_i;
    w_pop      = s_rvalid_i & (r_count != '0);
  end

  assign s_req_o   = ~rst_i & w_issue_ok & w_any_req;
  assign s_we_o    = w_sel_id ? m1_we_i    : m0_we_i;
  assign s_be_o    = w_sel_id ? m1_be_i    : m0_be_i;
  assign s_addr_o  = w_sel_id ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = w_sel_id ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o    = w_grant & ~w_sel_id;
  assign m1_gnt_o    = w_grant &  w_sel_id;
  assign m0_rvalid_o = ~rst_i & w_pop & ~w_head;
  assign m1_rvalid_o = ~rst_i & w_pop &  w_head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  assign busy_o = (r_count != '0);
  assign err_o  = r_err;

  // ID FIFO, round-robin history and sticky protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ids        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ids[r_wr_ptr] <= w_sel_id;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
        r_last_grant    <= w_sel_id;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (s_rvalid_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: grants and responses are checked by a
// negedge monitor against expectation queues filled by the stimulus.
`timescale 1ns/1ps
module tb_data_bus_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [3:0] m0_be, m1_be;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_req, s_we, s_gnt, s_rvalid;
  logic [3:0] s_be;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_gnt_q[$];
  logic [32:0] exp_rsp_q[$];
  logic        mon_gid;
  logic [32:0] mon_rsp;

  data_bus_arbiter #(.MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every grant and every routed response must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_gnt || m1_gnt) begin
        if (exp_gnt_q.size() == 0) begin
          chk("gnt_unexpected", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        end else begin
          mon_gid = exp_gnt_q.pop_front();
          chk("gnt_onehot", m0_gnt & m1_gnt, 0);
          chk("gnt_id", m1_gnt, mon_gid);
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          chk("rvalid_onehot", m0_rvalid & m1_rvalid, 0);
          chk("rvalid_id", m1_rvalid, mon_rsp[32]);
          chk("rdata", m1_rvalid ? m1_rdata : m0_rdata, mon_rsp[31:0]);
        end
      end
    end
  end

  logic [31:0] t2_data [4];

  initial begin
    t2_data = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hA0A0_0003, 32'hB1B1_0004};
    idle();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1;
    #1;
    chk("rst_sreq_forced", s_req, 0);
    chk("rst_gnt_forced", {m1_gnt, m0_gnt}, 0);
    chk("rst_rvalid_forced", {m1_rvalid, m0_rvalid}, 0);
    do_reset();

    // 1: single m0 read
    m0_req = 1; m0_addr = 32'h0000_0010; s_gnt = 1;
    exp_gnt_q.push_back(1'b0); exp_rsp_q.push_back({1'b0, 32'hDEAD_BEEF});
    #1;
    chk("t1_sreq", s_req, 1);
    chk("t1_addr", s_addr, 32'h0000_0010);
    chk("t1_m0_gnt", m0_gnt, 1);
    chk("t1_busy_pre", busy, 0);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_busy", busy, 1);
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    tick();
    idle();
    #1;
    chk("t1_busy_post", busy, 0);
    chk("t1_err", err, 0);

    // 2: contention, alternate grants and routed responses
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        m0_req = 1; m1_req = 1; s_gnt = 1;
        m0_addr = 32'h100; m1_addr = 32'h200;
        exp_gnt_q.push_back(1'(i % 2));
        exp_rsp_q.push_back({1'(i % 2), t2_data[i]});
      end
      if (i > 0) begin
        s_rvalid = 1; s_rdata = t2_data[i-1];
      end
      #1;
      if (i < 4) chk("t2_addr", s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end
    idle();

    // 3: backpressure on an m1 write
    m1_req = 1; m1_we = 1; m1_be = 4'h3; m1_addr = 32'h0000_6004; m1_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_sreq", s_req, 1);
      chk("t3_addr", s_addr, 32'h0000_6004);
      chk("t3_no_gnt", m1_gnt, 0);
      tick();
    end
    s_gnt = 1;
    exp_gnt_q.push_back(1'b1); exp_rsp_q.push_back({1'b1, 32'h1111_2222});
    #1;
    chk("t3_m1_gnt", m1_gnt, 1);
    chk("t3_we", s_we, 1);
    chk("t3_be", s_be, 4'h3);
    chk("t3_wdata", s_wdata, 32'hCAFE_F00D);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'h1111_2222;
    tick();
    idle();

    // 4: FIFO full, pop in same cycle does not allow issue
    m0_req = 1; s_gnt = 1;
    exp_gnt_q.push_back(1'b0); exp_rsp_q.push_back({1'b0, 32'hAAAA_0001});
    tick();
    idle(); m1_req = 1; s_gnt = 1;
    exp_gnt_q.push_back(1'b1); exp_rsp_q.push_back({1'b1, 32'hBBBB_0002});
    tick();
    idle(); m0_req = 1; s_gnt = 1;
    #1;
    chk("t4_full_sreq", s_req, 0);
    chk("t4_full_busy", busy, 1);
    tick();
    s_rvalid = 1; s_rdata = 32'hAAAA_0001;
    #1;
    chk("t4_pop_sreq", s_req, 0);
    chk("t4_pop_gnt", m0_gnt, 0);
    tick();
    s_rvalid = 0;
    exp_gnt_q.push_back(1'b0); exp_rsp_q.push_back({1'b0, 32'hCCCC_0003});
    #1;
    chk("t4_regrant", m0_gnt, 1);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'hBBBB_0002;
    tick();
    s_rdata = 32'hCCCC_0003;
    tick();
    idle();
    #1;
    chk("t4_busy_drained", busy, 0);

    // 5: spurious response sets sticky error
    s_rvalid = 1; s_rdata = 32'h5555_5555;
    #1;
    chk("t5_no_rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("t5_err_pre", err, 0);
    tick();
    idle();
    #1;
    chk("t5_err", err, 1);
    repeat (10) tick();
    chk("t5_err_sticky", err, 1);

    // 6: async reset with two outstanding
    m1_req = 1; s_gnt = 1;
    exp_gnt_q.push_back(1'b1);
    tick();
    idle(); m0_req = 1; s_gnt = 1;
    exp_gnt_q.push_back(1'b0);
    tick();
    m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1; s_rdata = 32'h7777_7777;
    #1;
    chk("t6_head_rvalid", m1_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rvalid_drop", {m1_rvalid, m0_rvalid}, 0);
    chk("t6_gnt_drop", {m1_gnt, m0_gnt}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err_clr", err, 0);
    @(posedge clk);
    #1;
    s_rvalid = 0;
    rst = 1'b0;
    exp_gnt_q.push_back(1'b0); exp_rsp_q.push_back({1'b0, 32'h5A5A_5A5A});
    #1;
    chk("t6_first_m0", m0_gnt, 1);
    tick();
    idle(); s_rvalid = 1; s_rdata = 32'h5A5A_5A5A;
    #1;
    chk("t6_m0_rvalid", m0_rvalid, 1);
    tick();
    idle();
    #1;
    chk("t6_busy_end", busy, 0);
    chk("t6_err_end", err, 0);

    tick();
    chk("gnt_q_drained", exp_gnt_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
